// File: rtl/proc_host_driver.sv
// Host-side command driver for a shared-bus processor: accepts one command, holds it on
// operation/addr/data for HOLD_CYCLES clocks, then returns a response with the captured data.
module proc_host_driver #(
    parameter int DATA_W      = 512,
    parameter int ADDR_W      = 9,
    parameter int HOLD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        operation,
    output logic [ADDR_W-1:0] addr,
    inout  wire  [DATA_W-1:0] data,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_STORE  = 2'b01;
    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic [1:0]          op_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [1:0]          operation_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                cmd_ready_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                busy_q;
    logic                drive_en;

    // Bus enable depends only on registers, so reset releases the bus without a clock edge.
    assign drive_en = (state_q == ST_DRIVE) && (op_q == OP_LOAD);
    assign data     = drive_en ? wdata_q : {DATA_W{1'bz}};

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign operation = operation_q;
    assign addr      = addr_q;
    assign busy      = busy_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            wdata_q     <= '0;
            operation_q <= OP_STORE;
            addr_q      <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        state_q     <= ST_DRIVE;
                        cnt_q       <= HOLD_LOAD;
                        op_q        <= cmd_op;
                        wdata_q     <= cmd_wdata;
                        operation_q <= cmd_op;
                        addr_q      <= cmd_addr;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == 4'd0) begin
                        // Last hold cycle: sample the bus and park the processor on a harmless Store.
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= (op_q == OP_STORE) ? data : '0;
                        operation_q <= OP_STORE;
                        addr_q      <= '0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_proc_host_driver.sv
// Directed bench for proc_host_driver: HOLD_CYCLES=2 instance (a) and HOLD_CYCLES=1 instance (b).
module tb_proc_host_driver;

    logic         clk;
    logic         reset;

    logic         a_cmd_valid, a_cmd_ready, a_rsp_valid, a_rsp_ready, a_busy;
    logic [1:0]   a_cmd_op, a_operation;
    logic [8:0]   a_cmd_addr, a_addr;
    logic [511:0] a_cmd_wdata, a_rsp_rdata, a_tb_drv;
    logic         a_tb_en;
    wire  [511:0] a_data;

    logic         b_cmd_valid, b_cmd_ready, b_rsp_valid, b_rsp_ready, b_busy;
    logic [1:0]   b_cmd_op, b_operation;
    logic [8:0]   b_cmd_addr, b_addr;
    logic [511:0] b_cmd_wdata, b_rsp_rdata, b_tb_drv;
    logic         b_tb_en;
    wire  [511:0] b_data;

    int checks;
    int errors;

    logic [511:0] pat_a5;
    logic [511:0] pat_3c;
    logic [511:0] pat_5a;

    assign a_data = a_tb_en ? a_tb_drv : {512{1'bz}};
    assign b_data = b_tb_en ? b_tb_drv : {512{1'bz}};

    proc_host_driver #(.DATA_W(512), .ADDR_W(9), .HOLD_CYCLES(2)) u_a (
        .clk(clk), .reset(reset),
        .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_op(a_cmd_op),
        .cmd_addr(a_cmd_addr), .cmd_wdata(a_cmd_wdata),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
        .operation(a_operation), .addr(a_addr), .data(a_data), .busy(a_busy)
    );

    proc_host_driver #(.DATA_W(512), .ADDR_W(9), .HOLD_CYCLES(1)) u_b (
        .clk(clk), .reset(reset),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_op(b_cmd_op),
        .cmd_addr(b_cmd_addr), .cmd_wdata(b_cmd_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
        .operation(b_operation), .addr(b_addr), .data(b_data), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_op(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ad(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        pat_a5 = {64{8'hA5}};
        pat_3c = {64{8'h3C}};
        pat_5a = {64{8'h5A}};
        reset = 1'b1;
        a_cmd_valid = 1'b0; a_cmd_op = 2'b00; a_cmd_addr = '0; a_cmd_wdata = '0;
        a_rsp_ready = 1'b0; a_tb_en = 1'b0; a_tb_drv = '0;
        b_cmd_valid = 1'b0; b_cmd_op = 2'b00; b_cmd_addr = '0; b_cmd_wdata = '0;
        b_rsp_ready = 1'b0; b_tb_en = 1'b0; b_tb_drv = '0;

        // Reset values
        #1 reset = 1'b0;
        #1;
        chk_b ("rst_cmd_ready", a_cmd_ready, 1'b1);
        chk_b ("rst_rsp_valid", a_rsp_valid, 1'b0);
        chk_b ("rst_busy",      a_busy,      1'b0);
        chk_op("rst_operation", a_operation, 2'b01);
        chk_ad("rst_addr",      a_addr,      9'd0);
        chk_w ("rst_rdata",     a_rsp_rdata, '0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Load op=00 addr=3
        @(negedge clk);
        $display("txn load  op=00 addr=3");
        a_cmd_valid = 1'b1; a_cmd_op = 2'b00; a_cmd_addr = 9'd3; a_cmd_wdata = pat_a5;
        @(negedge clk);
        a_cmd_valid = 1'b0;
        chk_b ("load_d1_busy",  a_busy,      1'b1);
        chk_b ("load_d1_ready", a_cmd_ready, 1'b0);
        chk_op("load_d1_op",    a_operation, 2'b00);
        chk_ad("load_d1_addr",  a_addr,      9'd3);
        chk_w ("load_d1_data",  a_data,      pat_a5);
        chk_b ("load_d1_rspv",  a_rsp_valid, 1'b0);
        @(negedge clk);
        chk_op("load_d2_op",    a_operation, 2'b00);
        chk_ad("load_d2_addr",  a_addr,      9'd3);
        chk_w ("load_d2_data",  a_data,      pat_a5);
        chk_b ("load_d2_rspv",  a_rsp_valid, 1'b0);
        @(negedge clk);
        chk_b ("load_rsp_valid", a_rsp_valid, 1'b1);
        chk_w ("load_rsp_rdata", a_rsp_rdata, '0);
        chk_op("load_rsp_op",    a_operation, 2'b01);
        chk_ad("load_rsp_addr",  a_addr,      9'd0);
        chk_b ("load_rsp_ready", a_cmd_ready, 1'b0);
        a_rsp_ready = 1'b1;
        @(negedge clk);
        chk_b ("load_idle_rspv",  a_rsp_valid, 1'b0);
        chk_b ("load_idle_ready", a_cmd_ready, 1'b1);
        chk_b ("load_idle_busy",  a_busy,      1'b0);
        // rsp_ready with no response pending
        @(negedge clk);
        chk_b ("idle_rspready_busy", a_busy,      1'b0);
        chk_b ("idle_rspready_rspv", a_rsp_valid, 1'b0);
        a_rsp_ready = 1'b0;

        // Store op=01 addr=1, bench owns the bus
        $display("txn store op=01 addr=1");
        a_cmd_valid = 1'b1; a_cmd_op = 2'b01; a_cmd_addr = 9'd1; a_cmd_wdata = pat_a5;
        a_tb_en = 1'b1; a_tb_drv = 512'h1234;
        @(negedge clk);
        a_cmd_valid = 1'b0;
        chk_op("store_d1_op",   a_operation, 2'b01);
        chk_ad("store_d1_addr", a_addr,      9'd1);
        chk_w ("store_d1_data", a_data,      512'h1234);
        @(negedge clk);
        chk_w ("store_d2_data", a_data,      512'h1234);
        chk_b ("store_d2_rspv", a_rsp_valid, 1'b0);
        @(negedge clk);
        chk_b ("store_rsp_valid", a_rsp_valid, 1'b1);
        chk_w ("store_rsp_rdata", a_rsp_rdata, 512'h1234);
        a_tb_en = 1'b0; a_tb_drv = 512'hFFFF;
        @(negedge clk);
        chk_b ("store_hold_valid", a_rsp_valid, 1'b1);
        chk_w ("store_hold_rdata", a_rsp_rdata, 512'h1234);
        a_rsp_ready = 1'b1;
        @(negedge clk);
        chk_b ("store_idle_ready", a_cmd_ready, 1'b1);
        a_rsp_ready = 1'b0;

        // Sum with back-pressure; stray cmd_valid must be ignored
        $display("txn sum   op=10 addr=5 backpressure");
        a_cmd_valid = 1'b1; a_cmd_op = 2'b10; a_cmd_addr = 9'd5;
        @(negedge clk);
        a_cmd_op = 2'b00; a_cmd_addr = 9'd7;
        chk_op("sum_d1_op",   a_operation, 2'b10);
        chk_ad("sum_d1_addr", a_addr,      9'd5);
        @(negedge clk);
        chk_op("sum_d2_op",   a_operation, 2'b10);
        chk_ad("sum_d2_addr", a_addr,      9'd5);
        for (int i = 0; i < 5; i++) begin
            a_cmd_valid = i[0];
            @(negedge clk);
            chk_b ("bp_rsp_valid", a_rsp_valid, 1'b1);
            chk_w ("bp_rsp_rdata", a_rsp_rdata, '0);
            chk_b ("bp_cmd_ready", a_cmd_ready, 1'b0);
            chk_op("bp_operation", a_operation, 2'b01);
        end
        a_cmd_valid = 1'b0;
        a_rsp_ready = 1'b1;
        @(negedge clk);
        chk_b ("bp_idle_ready", a_cmd_ready, 1'b1);
        chk_b ("bp_idle_busy",  a_busy,      1'b0);
        chk_b ("bp_idle_rspv",  a_rsp_valid, 1'b0);

        // Back-to-back: Product then Load with cmd_valid held
        $display("txn b2b   op=11 addr=4 then op=00 addr=6");
        a_cmd_valid = 1'b1; a_cmd_op = 2'b11; a_cmd_addr = 9'd4;
        @(negedge clk);
        chk_op("b2b_prod_op", a_operation, 2'b11);
        chk_ad("b2b_prod_addr", a_addr, 9'd4);
        @(negedge clk);
        @(negedge clk);
        chk_b ("b2b_prod_rspv", a_rsp_valid, 1'b1);
        a_cmd_op = 2'b00; a_cmd_addr = 9'd6; a_cmd_wdata = pat_3c;
        @(negedge clk);
        chk_b ("b2b_bubble_ready", a_cmd_ready, 1'b1);
        chk_b ("b2b_bubble_busy",  a_busy,      1'b0);
        chk_op("b2b_bubble_op",    a_operation, 2'b01);
        @(negedge clk);
        a_cmd_valid = 1'b0; a_rsp_ready = 1'b0;
        chk_b ("b2b_load_busy", a_busy,      1'b1);
        chk_op("b2b_load_op",   a_operation, 2'b00);
        chk_ad("b2b_load_addr", a_addr,      9'd6);
        chk_w ("b2b_load_data", a_data,      pat_3c);

        // Asynchronous reset in the middle of that Load
        $display("txn reset mid-drive");
        #2;
        reset = 1'b0;
        a_tb_en = 1'b1; a_tb_drv = pat_5a;
        #1;
        chk_w ("arst_data",      a_data,      pat_5a);
        chk_op("arst_operation", a_operation, 2'b01);
        chk_ad("arst_addr",      a_addr,      9'd0);
        chk_b ("arst_cmd_ready", a_cmd_ready, 1'b1);
        chk_b ("arst_rsp_valid", a_rsp_valid, 1'b0);
        chk_b ("arst_busy",      a_busy,      1'b0);
        @(negedge clk);
        reset = 1'b1; a_tb_en = 1'b0;

        // First command after reset release
        $display("txn sum   op=10 addr=8 after reset");
        a_cmd_valid = 1'b1; a_cmd_op = 2'b10; a_cmd_addr = 9'd8;
        @(negedge clk);
        a_cmd_valid = 1'b0; a_rsp_ready = 1'b1;
        chk_b ("post_rst_busy", a_busy,      1'b1);
        chk_op("post_rst_op",   a_operation, 2'b10);
        chk_ad("post_rst_addr", a_addr,      9'd8);
        chk_b ("post_rst_rspv", a_rsp_valid, 1'b0);
        @(negedge clk);
        chk_b ("post_rst_d2_rspv", a_rsp_valid, 1'b0);
        @(negedge clk);
        chk_b ("post_rst_rsp_valid", a_rsp_valid, 1'b1);
        chk_w ("post_rst_rsp_rdata", a_rsp_rdata, '0);
        @(negedge clk);
        chk_b ("post_rst_idle", a_cmd_ready, 1'b1);
        a_rsp_ready = 1'b0;

        // HOLD_CYCLES=1 instance: Store at addr 2
        $display("txn h1 store op=01 addr=2");
        b_cmd_valid = 1'b1; b_cmd_op = 2'b01; b_cmd_addr = 9'd2;
        b_tb_en = 1'b1; b_tb_drv = 512'hBEEF;
        @(negedge clk);
        b_cmd_valid = 1'b0;
        chk_b ("h1_d1_busy", b_busy,      1'b1);
        chk_op("h1_d1_op",   b_operation, 2'b01);
        chk_ad("h1_d1_addr", b_addr,      9'd2);
        chk_b ("h1_d1_rspv", b_rsp_valid, 1'b0);
        chk_w ("h1_d1_data", b_data,      512'hBEEF);
        @(negedge clk);
        b_tb_en = 1'b0;
        chk_b ("h1_rsp_valid", b_rsp_valid, 1'b1);
        chk_w ("h1_rsp_rdata", b_rsp_rdata, 512'hBEEF);
        chk_ad("h1_rsp_addr",  b_addr,      9'd0);
        b_rsp_ready = 1'b1;
        @(negedge clk);
        chk_b ("h1_idle_ready", b_cmd_ready, 1'b1);
        chk_b ("h1_idle_rspv",  b_rsp_valid, 1'b0);
        b_rsp_ready = 1'b0;

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/proc_host_driver.md
PROC_HOST_DRIVER -- requirements
Module: proc_host_driver

Interface
REQ-001 Parameter DATA_W, default 512, SHALL set the width of the processor data bus and command/response data.
REQ-002 Parameter ADDR_W, default 9, SHALL set the width of the processor address.
REQ-003 Parameter HOLD_CYCLES, default 2, range 1..15, SHALL set the number of clk cycles each command is presented to the processor.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 cmd_valid  input  1  host command request.
REQ-007 cmd_ready  output  1  driver can accept a command.
REQ-008 cmd_op  input  2  00 Load, 01 Store, 10 Sum, 11 Product.
REQ-009 cmd_addr  input  ADDR_W  processor address/register select.
REQ-010 cmd_wdata  input  DATA_W  data for Load.
REQ-011 rsp_valid  output  1  command complete, rsp_rdata valid.
REQ-012 rsp_ready  input  1  host accepts response.
REQ-013 rsp_rdata  output  DATA_W  data captured for Store, else zero.
REQ-014 operation  output  2  operation code to the processor.
REQ-015 addr  output  ADDR_W  address to the processor.
REQ-016 data  inout  DATA_W  shared processor data bus.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, DRIVE and RESP, each encoded in registered state.
REQ-019 In IDLE: cmd_ready=1, operation=2'b01 (Store, no write-enable, harmless), addr=0, data high-Z, rsp_valid=0.
REQ-020 cmd_valid&cmd_ready at rising edge N SHALL latch cmd_op/cmd_addr/cmd_wdata and enter DRIVE with the hold counter loaded to HOLD_CYCLES-1.
REQ-021 In DRIVE: operation and addr SHALL equal the latched values, stable for exactly HOLD_CYCLES cycles (edges N..N+HOLD_CYCLES), covering every processor falling-edge sample in that window.
REQ-022 In DRIVE with latched op=00, data SHALL be driven with latched wdata; for every other op data SHALL be high-Z.
REQ-023 The hold counter SHALL decrement each DRIVE cycle; at counter=0 the FSM SHALL go to RESP on the next edge.
REQ-024 On the DRIVE->RESP edge, rsp_rdata SHALL load the data bus value if op=01, otherwise all zeros.
REQ-025 rsp_valid SHALL first be high after edge N+HOLD_CYCLES (latency HOLD_CYCLES cycles from acceptance).
REQ-026 In RESP: rsp_valid=1, rsp_rdata stable, operation/addr return to idle values, data high-Z, cmd_ready=0.
REQ-027 rsp_valid&rsp_ready at an edge SHALL return to IDLE; rsp_valid and rsp_rdata SHALL hold while rsp_ready=0.
REQ-028 cmd_ready SHALL be 0 in DRIVE and RESP; cmd_valid there is ignored, with no latching and no effect.
REQ-029 cmd_valid high during RESP with rsp_ready SHALL NOT be accepted in that cycle; acceptance occurs in IDLE at the earliest one edge later (one-cycle bubble).
REQ-030 rsp_ready while rsp_valid=0 SHALL have no effect.
REQ-031 With HOLD_CYCLES=1 the DRIVE state SHALL last exactly one cycle.
REQ-032 The data tristate enable SHALL be a direct decode of registered state and latched op, with no combinational path from cmd_* inputs.

Reset
REQ-033 reset low SHALL asynchronously force IDLE: operation=01, addr=0, data high-Z, cmd_ready=1, rsp_valid=0, rsp_rdata=0, busy=0, counter=0, latched command=0.
REQ-034 Reset asserted mid-DRIVE or mid-RESP SHALL abort the command with no response, and release the bus immediately.
REQ-035 After reset deasserts, the first rising edge with cmd_valid=1 SHALL be accepted normally.

Verification
REQ-036 Load: op=00, addr=3, wdata=512'hA5 pattern, HOLD_CYCLES=2 -> data driven 512'hA5.. and operation=00/addr=3 for 2 cycles; rsp_valid after 2 cycles; rsp_rdata=0.
REQ-037 Store: op=01, addr=1, bench drives data=512'h1234 during DRIVE -> rsp_rdata=512'h1234; driver data high-Z throughout.
REQ-038 Back-pressure: Sum op=10, rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata=0 held; cmd_valid pulses ignored; IDLE one edge after rsp_ready=1.
REQ-039 Back-to-back: cmd_valid held with Product (11) then Load -> second acceptance no earlier than one cycle after the response handshake.
REQ-040 Reset mid-DRIVE of a Load -> data high-Z, operation=01, addr=0, cmd_ready=1 without waiting for clk; no rsp_valid.
REQ-041 HOLD_CYCLES=1 build: Store at addr=2 -> rsp_valid one cycle after acceptance, carrying the captured bus value.
